// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant, or fixed priority under ALU_ARB_FIXED_PRIO_EN.
// Latency: accept at edge N, ALU inputs valid in cycle N+1, response registered at edge N+1; 1 op/cycle.
// Backpressure: rsp_ready low holds the response, then the issue stage fills and req_ready drops to all-zero.
module alu_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*FUNC_WIDTH-1:0] req_func,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c,
    output logic [FUNC_WIDTH-1:0]         alu_func,
    output logic [DATA_WIDTH-1:0]         alu_in1,
    output logic [DATA_WIDTH-1:0]         alu_in2,
    output logic [DATA_WIDTH-1:0]         alu_in3,
    input  logic [DATA_WIDTH-1:0]         alu_out,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id
);

    logic                  iss_vld;
    logic [ID_WIDTH-1:0]   iss_id;
    logic                  resp_move;
    logic                  iss_free;
    logic                  any_grant;
    logic                  hs;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    rot;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH:0]     sum;
    logic [FUNC_WIDTH-1:0] sel_func;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [DATA_WIDTH-1:0] sel_c;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [ID_WIDTH-1:0]    rr_ptr;
    logic [ID_WIDTH-1:0]    next_ptr;
    logic [2*NUM_REQ-1:0]   dbl;
`endif

    assign resp_move = iss_vld & (~rsp_valid | rsp_ready);
    assign iss_free  = ~iss_vld | resp_move;
    assign hs        = rst & iss_free & any_grant;
    assign req_ready = (rst && iss_free) ? grant : '0;

    // Search a rotated copy of req_valid so bit 0 is always the current priority holder.
    always_comb begin
        any_grant = 1'b0;
        grant_id  = '0;
        sum       = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        rot = req_valid;
`else
        dbl = {req_valid, req_valid} >> rr_ptr;
        rot = dbl[NUM_REQ-1:0];
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_grant && rot[k]) begin
                any_grant = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
                sum = (ID_WIDTH+1)'(k);
`else
                sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
                if (sum >= (ID_WIDTH+1)'(NUM_REQ))
                    sum = sum - (ID_WIDTH+1)'(NUM_REQ);
`endif
                grant_id = sum[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        grant    = '0;
        sel_func = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_c    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (any_grant && grant_id == ID_WIDTH'(i)) begin
                grant[i] = 1'b1;
                sel_func = req_func[i*FUNC_WIDTH +: FUNC_WIDTH];
                sel_a    = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b    = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                sel_c    = req_c[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    assign next_ptr = (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_vld   <= 1'b0;
            iss_id    <= '0;
            alu_func  <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_in3   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            if (resp_move) begin
                rsp_data  <= alu_out;
                rsp_id    <= iss_id;
                rsp_valid <= 1'b1;
            end else if (rsp_ready && rsp_valid) begin
                rsp_valid <= 1'b0;
            end

            // Operand registers keep their last value when the issue stage empties.
            if (iss_free) begin
                if (hs) begin
                    iss_vld  <= 1'b1;
                    iss_id   <= grant_id;
                    alu_func <= sel_func;
                    alu_in1  <= sel_a;
                    alu_in2  <= sel_b;
                    alu_in3  <= sel_c;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    rr_ptr   <= next_ptr;
`endif
                end else begin
                    iss_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: bench-side ALU model drives alu_out,
// expected responses are queued at grant time and matched in order when the DUT hands them off.
module tb_alu_share_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int FW = 4;
    localparam int IW = 2;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*FW-1:0] req_func;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR*DW-1:0] req_c;
    logic [FW-1:0]    alu_func;
    logic [DW-1:0]    alu_in1;
    logic [DW-1:0]    alu_in2;
    logic [DW-1:0]    alu_in3;
    logic [DW-1:0]    alu_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic [IW-1:0]    rsp_id;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks   = 0;
    int            failures = 0;
    logic [FW-1:0] pf[NR];
    logic [DW-1:0] pa[NR];
    logic [DW-1:0] pb[NR];
    logic [DW-1:0] pc[NR];
    bit            fixed_prio;
    int            e0;
    int            e1;
    int            e;

    alu_share_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .FUNC_WIDTH(FW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_func(req_func), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .alu_func(alu_func), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_in3(alu_in3),
        .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    function automatic logic [DW-1:0] alu_model(input logic [FW-1:0] f, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b, input logic [DW-1:0] c);
        case (f)
            4'd0:    return a ^ b ^ c;
            4'd1:    return a + b + c;
            4'd2:    return a - b;
            4'd3:    return a * b + c;
            default: return a | b;
        endcase
    endfunction

    assign alu_out = alu_model(alu_func, alu_in1, alu_in2, alu_in3);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [FW-1:0] f, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] c);
        pf[i] = f; pa[i] = a; pb[i] = b; pc[i] = c;
        req_func[i*FW +: FW] = f;
        req_a[i*DW +: DW]    = a;
        req_b[i*DW +: DW]    = b;
        req_c[i*DW +: DW]    = c;
    endtask

    task automatic push_exp(input int i);
        exp_t x;
        x.id   = IW'(i);
        x.data = alu_model(pf[i], pa[i], pb[i], pc[i]);
        sb.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b0;
        #1;
        sb.delete();
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        rst = 1'b1;
    endtask

    // Response handoff happens at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_extra", {63'b0, rsp_valid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", {62'b0, rsp_id}, {62'b0, mon_e.id});
                check("rsp_data", {32'b0, rsp_data}, {32'b0, mon_e.data});
            end
        end
    end

    initial begin
        fixed_prio = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        fixed_prio = 1'b1;
`endif
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        req_func  = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        for (int i = 0; i < NR; i++) set_req(i, FW'(i), DW'(10*i + 1), DW'(i + 3), 32'd2);

        // Reset state, with requests already valid
        #2;
        check("rst_req_ready", {60'b0, req_ready}, 64'd0);
        check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("rst_alu_func", {60'b0, alu_func}, 64'd0);
        check("rst_alu_in1", {32'b0, alu_in1}, 64'd0);
        check("rst_rsp_data", {32'b0, rsp_data}, 64'd0);
        check("rst_rsp_id", {62'b0, rsp_id}, 64'd0);
        req_valid = '0;
        tick();
        rst = 1'b1;

        // Single request from requester 2
        set_req(2, 4'd1, 32'd5, 32'd7, 32'd0);
        req_valid = 4'b0100;
        #1;
        check("single_ready", {60'b0, req_ready}, 64'h4);
        push_exp(2);
        tick();
        req_valid = '0;
        #1;
        check("single_alu_in1", {32'b0, alu_in1}, 64'd5);
        check("single_alu_in2", {32'b0, alu_in2}, 64'd7);
        check("single_alu_in3", {32'b0, alu_in3}, 64'd0);
        check("single_alu_func", {60'b0, alu_func}, 64'd1);
        check("single_no_rsp_yet", {63'b0, rsp_valid}, 64'd0);
        tick();
        check("single_rsp_valid", {63'b0, rsp_valid}, 64'd1);
        check("single_rsp_id", {62'b0, rsp_id}, 64'd2);
        check("single_rsp_data", {32'b0, rsp_data}, 64'd12);
        check("single_operand_hold", {32'b0, alu_in1}, 64'd5);
        tick();
        tick();
        check("single_drain", 64'(sb.size()), 64'd0);

        // Fairness with all requesters valid
        reset_dut();
        for (int i = 0; i < NR; i++) set_req(i, FW'(i), DW'(10*i + 1), DW'(i + 3), 32'd2);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            e = fixed_prio ? 0 : (k % NR);
            #1;
            check("fair_ready", {60'b0, req_ready}, 64'(1) << e);
            if (k >= 2) check("fair_rsp_valid", {63'b0, rsp_valid}, 64'd1);
            push_exp(e);
            tick();
        end
        req_valid = '0;
        tick(); tick(); tick();
        check("fair_drain", 64'(sb.size()), 64'd0);

        // Backpressure: two accepts fill both stages, then everything holds
        reset_dut();
        for (int i = 0; i < NR; i++) set_req(i, FW'(3), DW'(100 + i), DW'(i + 2), DW'(7 * i));
        rsp_ready = 1'b0;
        req_valid = '1;
        e0 = 0;
        e1 = fixed_prio ? 0 : 1;
        #1;
        check("bp_ready0", {60'b0, req_ready}, 64'(1) << e0);
        push_exp(e0);
        tick();
        #1;
        check("bp_ready1", {60'b0, req_ready}, 64'(1) << e1);
        push_exp(e1);
        tick();
        for (int s = 0; s < 4; s++) begin
            #1;
            check("bp_ready_stall", {60'b0, req_ready}, 64'd0);
            check("bp_rsp_valid", {63'b0, rsp_valid}, 64'd1);
            check("bp_rsp_id", {62'b0, rsp_id}, 64'(e0));
            check("bp_rsp_data", {32'b0, rsp_data}, {32'b0, alu_model(pf[e0], pa[e0], pb[e0], pc[e0])});
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check("bp_drain", 64'(sb.size()), 64'd0);

        // Only requesters 1 and 3 active
        reset_dut();
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            e = fixed_prio ? 1 : ((k % 2 == 0) ? 1 : 3);
            #1;
            check("skip_ready", {60'b0, req_ready}, 64'(1) << e);
            push_exp(e);
            tick();
        end
        req_valid = '0;
        tick(); tick(); tick();
        check("skip_drain", 64'(sb.size()), 64'd0);

        // Asynchronous reset with both stages occupied
        reset_dut();
        rsp_ready = 1'b0;
        req_valid = '1;
        tick();
        tick();
        check("midrst_pre_rsp_valid", {63'b0, rsp_valid}, 64'd1);
        rst = 1'b0;
        #1;
        check("midrst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("midrst_req_ready", {60'b0, req_ready}, 64'd0);
        check("midrst_alu_func", {60'b0, alu_func}, 64'd0);
        check("midrst_alu_in1", {32'b0, alu_in1}, 64'd0);
        check("midrst_alu_in2", {32'b0, alu_in2}, 64'd0);
        check("midrst_alu_in3", {32'b0, alu_in3}, 64'd0);
        check("midrst_rsp_data", {32'b0, rsp_data}, 64'd0);
        sb.delete();
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("midrst_no_stale", {63'b0, rsp_valid}, 64'd0);
        req_valid = 4'b0110;
        #1;
        check("midrst_first_grant", {60'b0, req_ready}, 64'h2);
        push_exp(1);
        tick();
        req_valid = '0;
        tick(); tick();
        check("midrst_drain", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one fabric ALU instance among NUM_REQ requesters.
- Each requester presents its function code and three operands with a valid/ready handshake.
- The block picks one requester per cycle (round-robin), registers that request onto the ALU inputs, and captures the ALU result into a response register tagged with the requester index.
- Sits between the PE-local routing and the ALU; the ALU itself stays purely combinational.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, operand/result width; matches ALU data ports.
- FUNC_WIDTH, 4, width of the per-request ALU function code.
- ID_WIDTH, $clog2(NUM_REQ), width of the response tag.

Ports:
- clk  input  1  fabric clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_func  input  NUM_REQ*FUNC_WIDTH  function codes; requester i at slice i.
- req_a  input  NUM_REQ*DATA_WIDTH  operand 1 per requester.
- req_b  input  NUM_REQ*DATA_WIDTH  operand 2 per requester.
- req_c  input  NUM_REQ*DATA_WIDTH  operand 3 per requester.
- alu_func  output  FUNC_WIDTH  function select to ALU.
- alu_in1  output  DATA_WIDTH  to ALU data_in1.
- alu_in2  output  DATA_WIDTH  to ALU data_in2.
- alu_in3  output  DATA_WIDTH  to ALU data_in3.
- alu_out  input  DATA_WIDTH  from ALU data_out (combinational).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  DATA_WIDTH  registered ALU result.
- rsp_id  output  ID_WIDTH  index of the requester that issued it.

Behaviour:
- Pipeline has two registered stages:
  - ISSUE (iss_vld, iss_id, alu_func, alu_in1..3)
  - RESP (rsp_valid, rsp_id, rsp_data)
- Reset (rst low, async):
  - iss_vld=0, rsp_valid=0, rr_ptr=0.
  - alu_func=0, alu_in1..3=0, rsp_data=0, rsp_id=0.
  - req_ready=0 while reset is asserted.
- RESP stage:
  - resp_move = iss_vld & (~rsp_valid | rsp_ready).
  - On resp_move: rsp_data<=alu_out, rsp_id<=iss_id, rsp_valid<=1.
  - Otherwise, if rsp_ready and rsp_valid: rsp_valid<=0.
- ISSUE stage:
  - iss_free = ~iss_vld | resp_move.
- Grant (combinational):
  - First i with req_valid[i], searching from rr_ptr upward, modulo NUM_REQ.
  - req_ready[i] = grant[i] & iss_free.
- Handshake on req_valid[i] & req_ready[i]:
  - Load alu_func/alu_in1..3 from slice i, iss_id<=i, iss_vld<=1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- If iss_free and no request: iss_vld<=0; operand registers hold their last value (no zeroing).
- rr_ptr changes only on a handshake; a requester dropping valid without a handshake does not move it.
- Latency: accept at edge N; ALU inputs valid during cycle N+1; rsp_valid high from edge N+1. One cycle from handshake to response.
- Throughput: 1 op/cycle with rsp_ready held high. Max 2 ops in flight.
- Backpressure:
  - rsp_valid=1 and rsp_ready=0 holds rsp_data/rsp_id stable.
  - ISSUE holds if full; req_ready goes all-zero.
- Simultaneous response drain and new accept in the same cycle is legal and must not drop or duplicate data.
- Requesters keep req_valid and payload stable until accepted. req_ready may depend on req_valid.
- Reset mid-operation: in-flight ops are discarded; no response is issued for them after reset releases.
- Arithmetic: no width conversion; alu_out is captured unmodified.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: grant is strict fixed priority, lowest index wins; rr_ptr logic is removed.
- Undefined (default): round-robin as above.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- Single request: req_valid[2]=1, a=5, b=7, c=0, func=1; rsp_ready=1. Required: req_ready[2]=1 in that cycle; next cycle alu_in1=5, alu_in2=7, alu_func=1; following edge rsp_valid=1, rsp_data=ALU model result, rsp_id=2.
- Fairness: all 4 req_valid held high for 8 cycles, rsp_ready=1. Required: rsp_id sequence 0,1,2,3,0,1,2,3 with rsp_valid continuously 1. With ALU_ARB_FIXED_PRIO_EN: all 8 responses have rsp_id=0.
- Backpressure: rsp_ready=0 with continuous requests. Required: exactly 2 handshakes occur, then req_ready=0; rsp_data/rsp_id stay constant. After rsp_ready=1: responses drain in order, none lost.
- Skip idle: only req_valid[1] and req_valid[3] high, rr_ptr=0. Required: grants 1,3,1,3; rr_ptr never selects 0 or 2.
- Reset mid-op: assert rst low asynchronously while iss_vld=1 and rsp_valid=1. Required: rsp_valid=0 immediately without waiting for a clock edge; all ALU inputs read 0; after release, no stale response; first grant goes to the lowest valid index from 0.
